// File: rtl/draw_sequencer_pkg.sv
// draw_sequencer_pkg
// Shared constants for the VGA draw path: screen and sprite geometry, the
// sequencer state encoding, the command-kind enum, and the image IDs the
// colour mux decodes from memorySel.
package draw_sequencer_pkg;

    localparam int DS_SCREEN_W = 160;
    localparam int DS_SCREEN_H = 120;
    localparam int DS_SPRITE_W = 40;
    localparam int DS_SPRITE_H = 40;

    // Sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SCAN  = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [1:0] {
        CMD_SCREEN = 2'd0,
        CMD_SPRITE = 2'd1,
        CMD_ERASE  = 2'd2
    } cmd_kind_t;

    // Image IDs understood by the colour mux
    localparam logic [4:0] IMG_NONE       = 5'd0;
    localparam logic [4:0] IMG_TITLE      = 5'd1;
    localparam logic [4:0] IMG_BACKGROUND = 5'd3;
    localparam logic [4:0] IMG_PLAYER     = 5'd12;

    // Fixed priority: screen > erase > sprite
    function automatic cmd_kind_t arbitrate(input logic scr, input logic era);
        if (scr)      return CMD_SCREEN;
        else if (era) return CMD_ERASE;
        else          return CMD_SPRITE;
    endfunction

endpackage

// File: rtl/raster_scanner.sv
// raster_scanner
// Row-major col/row walker with a linear address counter.
// Ports:
//   clk, rst          clock, async active-high reset
//   i_clear           zero all counters (LOAD)
//   i_step            advance one pixel (SCAN)
//   i_screen          route the address to the screen ROM, else sprite ROM
//   i_w, i_h          raster width / height for the current command
//   o_col, o_row      current pixel position
//   o_last            current pixel is (W-1, H-1)
//   o_screen_addr     screen ROM address (0 when the sprite ROM is in use)
//   o_sprite_addr     sprite ROM address (0 when the screen ROM is in use)
module raster_scanner (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_step,
    input  logic        i_screen,
    input  logic [7:0]  i_w,
    input  logic [6:0]  i_h,
    output logic [7:0]  o_col,
    output logic [6:0]  o_row,
    output logic        o_last,
    output logic [14:0] o_screen_addr,
    output logic [10:0] o_sprite_addr
);

    logic [7:0]  r_col;
    logic [6:0]  r_row;
    logic [14:0] r_addr;
    logic        w_col_end;
    logic        w_row_end;

    assign w_col_end = (r_col == i_w - 8'd1);
    assign w_row_end = (r_row == i_h - 7'd1);
    assign o_last    = w_col_end & w_row_end;

    // Counters fall back to 0 after the last pixel so both ROM addresses
    // idle at 0 between commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_clear || (i_step && o_last)) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_step) begin
            r_addr <= r_addr + 15'd1;
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + 7'd1;
            end else begin
                r_col <= r_col + 8'd1;
            end
        end
    end

    assign o_col         = r_col;
    assign o_row         = r_row;
    assign o_screen_addr = i_screen ? r_addr : 15'd0;
    assign o_sprite_addr = i_screen ? 11'd0 : r_addr[10:0];

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer
// Control FSM for the VGA pixel datapath. Accepts one draw command at a
// time (full screen, sprite box, black erase box), walks the ROM addresses
// row-major and emits the matching pixel stream one cycle later to line up
// with the 1-cycle ROM read.
// Ports:
//   clk, reset                       clock, async active-high reset
//   screenReq/spriteReq/eraseReq     level requests (screen > erase > sprite)
//   imageSel, originX, originY       command operands, latched on accept
//   ack                              1-cycle pulse: command accepted
//   busy                             ack cycle through done cycle
//   done                             1-cycle pulse after the last pixel
//   screenAddr, spriteAddr           ROM addresses
//   memorySel, x, y, black, plot     pixel stream to colour mux / VGA
module draw_sequencer
    import draw_sequencer_pkg::*;
#(
    parameter int SCREEN_W = DS_SCREEN_W,
    parameter int SCREEN_H = DS_SCREEN_H,
    parameter int SPRITE_W = DS_SPRITE_W,
    parameter int SPRITE_H = DS_SPRITE_H
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screenReq,
    input  logic        spriteReq,
    input  logic        eraseReq,
    input  logic [4:0]  imageSel,
    input  logic [7:0]  originX,
    input  logic [6:0]  originY,
    output logic        ack,
    output logic        busy,
    output logic        done,
    output logic [14:0] screenAddr,
    output logic [10:0] spriteAddr,
    output logic [4:0]  memorySel,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic        black,
    output logic        plot
);

    logic [2:0]  r_state;
    cmd_kind_t   r_kind;
    logic [4:0]  r_img;
    logic [7:0]  r_ox;
    logic [6:0]  r_oy;
    logic        r_ack;
    logic        r_busy;
    logic        r_done;

    logic        r_plot;
    logic        r_black;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [4:0]  r_msel;

    logic        w_accept;
    logic        w_scan;
    logic        w_screen;
    logic [7:0]  w_w;
    logic [6:0]  w_h;
    logic [7:0]  w_col;
    logic [6:0]  w_row;
    logic        w_last;
    logic [8:0]  w_x_full;
    logic [7:0]  w_y_full;
    logic        w_on_screen;

    assign w_accept = (r_state == ST_IDLE) && (screenReq || eraseReq || spriteReq);
    assign w_scan   = (r_state == ST_SCAN);
    assign w_screen = (r_kind == CMD_SCREEN);
    assign w_w      = w_screen ? 8'(SCREEN_W) : 8'(SPRITE_W);
    assign w_h      = w_screen ? 7'(SCREEN_H) : 7'(SPRITE_H);

    raster_scanner u_scan (
        .clk           (clk),
        .rst           (reset),
        .i_clear       (r_state == ST_LOAD),
        .i_step        (w_scan),
        .i_screen      (w_screen),
        .i_w           (w_w),
        .i_h           (w_h),
        .o_col         (w_col),
        .o_row         (w_row),
        .o_last        (w_last),
        .o_screen_addr (screenAddr),
        .o_sprite_addr (spriteAddr)
    );

    // Control FSM. busy covers the ack cycle through the done cycle; a held
    // request is re-arbitrated in the done cycle, giving ack one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_kind  <= CMD_SCREEN;
            r_img   <= IMG_NONE;
            r_ox    <= '0;
            r_oy    <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ack  <= w_accept;
            r_busy <= w_accept || (r_state != ST_IDLE);
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_kind  <= arbitrate(screenReq, eraseReq);
                        r_img   <= imageSel;
                        r_ox    <= originX;
                        r_oy    <= originY;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD:  r_state <= ST_SCAN;
                ST_SCAN:  if (w_last) r_state <= ST_FLUSH;
                ST_FLUSH: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Box coordinates are formed one bit wider so off-screen pixels can be
    // detected and suppressed instead of wrapping.
    assign w_x_full    = w_screen ? {1'b0, w_col} : ({1'b0, r_ox} + {1'b0, w_col});
    assign w_y_full    = w_screen ? {1'b0, w_row} : ({1'b0, r_oy} + {1'b0, w_row});
    assign w_on_screen = (w_x_full < 9'(SCREEN_W)) && (w_y_full < 8'(SCREEN_H));

    // Pixel stage: registered one cycle after the address to match ROM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_plot  <= 1'b0;
            r_black <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_msel  <= '0;
        end else begin
            r_plot  <= w_scan && w_on_screen;
            r_black <= w_scan && (r_kind == CMD_ERASE);
            if (w_scan) begin
                r_x    <= w_x_full[7:0];
                r_y    <= w_y_full[6:0];
                r_msel <= r_img;
            end
        end
    end

    assign ack       = r_ack;
    assign busy      = r_busy;
    assign done      = r_done;
    assign plot      = r_plot;
    assign black     = r_black;
    assign x         = r_x;
    assign y         = r_y;
    assign memorySel = r_msel;

endmodule
